// File: rtl/byte_shift_counter_pkg.sv
// Shared constants for the byte-serial capture front end.
// Defaults describe an 8-byte command word.
package byte_shift_counter_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEF_NUM_BYTES = 8;
    localparam int DEF_MAX_COUNT = 8;
    localparam int DEF_CNT_WIDTH = 4;

    function automatic int word_bits(input int n_bytes);
        return n_bytes * BYTE_W;
    endfunction

endpackage

// File: rtl/byte_shift_counter_if.sv
// Byte bus and capture status bundle between the byte source
// and the capture front end.
import byte_shift_counter_pkg::*;

interface byte_shift_counter_if #(
    parameter int NUM_BYTES = DEF_NUM_BYTES,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
    logic                          en;
    logic                          clr;
    logic [BYTE_W-1:0]             data_in;
    logic [NUM_BYTES*BYTE_W-1:0]   word_out;
    logic [CNT_WIDTH-1:0]          count;
    logic                          full;

    modport master (
        output en,
        output clr,
        output data_in,
        input  word_out,
        input  count,
        input  full
    );

    modport slave (
        input  en,
        input  clr,
        input  data_in,
        output word_out,
        output count,
        output full
    );
endinterface

// File: rtl/byte_shift_reg.sv
// Wide shift register taking one byte per enabled clock; newest at the MSB.
import byte_shift_counter_pkg::*;

module byte_shift_reg #(
    parameter int NUM_BYTES = DEF_NUM_BYTES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [BYTE_W-1:0]           data_in,
    output logic [NUM_BYTES*BYTE_W-1:0] word_out
);
    localparam int W = NUM_BYTES * BYTE_W;

    logic [W-1:0] r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
        end else if (en) begin
            r_word <= {data_in, r_word[W-1:BYTE_W]};
        end
    end

    assign word_out = r_word;
endmodule

// File: rtl/up_counter_sat.sv
// Up counter with synchronous clear that holds at MAX instead of wrapping.
import byte_shift_counter_pkg::*;

module up_counter_sat #(
    parameter int WIDTH = DEF_CNT_WIDTH,
    parameter int MAX   = DEF_MAX_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == WIDTH'(MAX));

    // clr outranks en so a new command always restarts from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && !w_at_max) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;
endmodule

// File: rtl/byte_shift_counter.sv
// Byte-serial capture: shifts bus bytes into a wide word and counts them,
// flagging full once a complete command has been captured.
import byte_shift_counter_pkg::*;

module byte_shift_counter #(
    parameter int NUM_BYTES = DEF_NUM_BYTES,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int MAX_COUNT = DEF_MAX_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    byte_shift_counter_if.slave  bus
);
    logic [CNT_WIDTH-1:0]        w_count;
    logic [NUM_BYTES*BYTE_W-1:0] w_word;

    byte_shift_reg #(
        .NUM_BYTES (NUM_BYTES)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.en),
        .data_in  (bus.data_in),
        .word_out (w_word)
    );

    up_counter_sat #(
        .WIDTH (CNT_WIDTH),
        .MAX   (MAX_COUNT)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en),
        .clr   (bus.clr),
        .count (w_count)
    );

    assign bus.word_out = w_word;
    assign bus.count    = w_count;
    assign bus.full     = (w_count == CNT_WIDTH'(MAX_COUNT));
endmodule

// File: tb/tb_byte_shift_counter.sv
// Directed bench for byte_shift_counter with hand-computed expectations.
import byte_shift_counter_pkg::*;

module tb_byte_shift_counter;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    byte_shift_counter_if #(.NUM_BYTES(8), .CNT_WIDTH(4)) bus ();

    byte_shift_counter #(
        .NUM_BYTES (8),
        .CNT_WIDTH (4),
        .MAX_COUNT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic [7:0] d);
        bus.en      = e;
        bus.clr     = c;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [63:0] w,
                           input logic [3:0] c, input logic f);
        chk({tag, ".word"},  bus.word_out,    w);
        chk({tag, ".count"}, 64'(bus.count),  64'(c));
        chk({tag, ".full"},  64'(bus.full),   64'(f));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        step(1'b1, 1'b0, 8'hFF);
        chk_all("reset", 64'h0, 4'd0, 1'b0);

        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b0, 8'(i));
        end
        chk_all("seven", 64'h0706050403020100, 4'd7, 1'b0);

        step(1'b1, 1'b0, 8'h08);
        chk_all("eight", 64'h0807060504030201, 4'd8, 1'b1);

        step(1'b1, 1'b0, 8'h09);
        chk_all("sat", 64'h0908070605040302, 4'd8, 1'b1);

        step(1'b0, 1'b1, 8'h55);
        chk_all("clr", 64'h0908070605040302, 4'd0, 1'b0);

        step(1'b1, 1'b1, 8'hAA);
        chk_all("clr_en", 64'hAA09080706050403, 4'd0, 1'b0);

        step(1'b1, 1'b0, 8'h11);
        chk_all("tog1", 64'h11AA090807060504, 4'd1, 1'b0);
        step(1'b0, 1'b0, 8'h22);
        chk_all("tog0", 64'h11AA090807060504, 4'd1, 1'b0);
        step(1'b1, 1'b0, 8'h33);
        chk_all("tog2", 64'h3311AA0908070605, 4'd2, 1'b0);

        rst = 1'b1;
        step(1'b1, 1'b0, 8'h44);
        chk_all("midrst", 64'h0, 4'd0, 1'b0);

        rst = 1'b0;
        step(1'b0, 1'b0, 8'h77);
        chk_all("idle", 64'h0, 4'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
